// File: rtl/bcd_counter_7seg_n_if.sv
// bcd_counter_7seg_n_if
//   Control and display bundle for the N-digit BCD counter. clock and reset
//   are kept as plain ports on the counter itself.
//   enable, up_down, load, load_value, lamp_test, blank_leading : master -> slave
//   count, sg7, tick, wrap                                      : slave -> master
//   load_value/count pack digit k at [4k+3:4k]; sg7 packs digit k at
//   [7k+6:7k] as {g,f,e,d,c,b,a}.
interface bcd_counter_7seg_n_if #(
   parameter int DIGITS = 8
);
   logic                  enable;
   logic                  up_down;
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  lamp_test;
   logic                  blank_leading;
   logic [4*DIGITS-1:0]   count;
   logic [7*DIGITS-1:0]   sg7;
   logic                  tick;
   logic                  wrap;

   modport master (
      output enable, up_down, load, load_value, lamp_test, blank_leading,
      input  count, sg7, tick, wrap
   );

   modport slave (
      input  enable, up_down, load, load_value, lamp_test, blank_leading,
      output count, sg7, tick, wrap
   );
endinterface

// File: rtl/bcd_counter_7seg_n.sv
// bcd_counter_7seg_n
//   DIGITS-digit decimal up/down counter stepped by a TICK_DIV prescaler,
//   with parallel load, wrap pulse, leading-zero blanking, lamp test and a
//   registered 7-segment output of selectable polarity.
//   clock : single clock, all state changes on its rising edge
//   reset : synchronous, active high
//   bus   : bcd_counter_7seg_n_if.slave (controls in; count/sg7/tick/wrap out)

// Per-digit segment lane: decode, then blank / lamp / enable override,
// then polarity. Purely combinational; the top registers the result.
module bcd_counter_7seg_lane #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       enable,
   input  logic       lamp_test,
   output logic [6:0] seg
);
   logic [6:0] dec;
   logic [6:0] lit;

   always_comb begin
      dec = '0;
      case (digit)
         4'd0: dec = 7'h3F;
         4'd1: dec = 7'h06;
         4'd2: dec = 7'h5B;
         4'd3: dec = 7'h4F;
         4'd4: dec = 7'h66;
         4'd5: dec = 7'h6D;
         4'd6: dec = 7'h7D;
         4'd7: dec = 7'h07;
         4'd8: dec = 7'h7F;
         4'd9: dec = 7'h6F;
         default: dec = '0;
      endcase
      lit = dec;
      if (!enable)        lit = '0;
      else if (lamp_test) lit = 7'h7F;
      else if (blank)     lit = '0;
   end

   assign seg = ACTIVE_LOW ? ~lit : lit;
endmodule

module bcd_counter_7seg_n #(
   parameter int DIGITS     = 8,
   parameter int TICK_DIV   = 50_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic                  clock,
   input logic                  reset,
   bcd_counter_7seg_n_if.slave  bus
);
   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [6:0]    SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [PW-1:0]          presc;
   logic [DIGITS-1:0][3:0] cnt, cnt_nxt, load_clamped;
   logic [DIGITS-1:0]      blank;
   logic [DIGITS-1:0][6:0] seg_nxt, sg7_q;
   logic                   run, step, roll, lz, tick_q, wrap_q;

   // Prescaler and counting freeze together under lamp test or disable.
   assign run  = bus.enable & ~bus.lamp_test;
   assign step = run && (presc == PRESC_LAST);

   // Single ripple chain serves as carry (up) or borrow (down); a chain
   // that survives past the top digit is the wrap condition.
   always_comb begin
      cnt_nxt = cnt;
      roll    = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (roll) begin
            if (bus.up_down) begin
               if (cnt[k] == 4'd9) cnt_nxt[k] = 4'd0;
               else begin
                  cnt_nxt[k] = cnt[k] + 4'd1;
                  roll       = 1'b0;
               end
            end else begin
               if (cnt[k] == 4'd0) cnt_nxt[k] = 4'd9;
               else begin
                  cnt_nxt[k] = cnt[k] - 4'd1;
                  roll       = 1'b0;
               end
            end
         end
      end
   end

   // Out-of-range load digits saturate so the count never leaves 0..9.
   always_comb begin
      load_clamped = '0;
      for (int k = 0; k < DIGITS; k++)
         load_clamped[k] = (bus.load_value[4*k +: 4] > 4'd9) ? 4'd9 : bus.load_value[4*k +: 4];
   end

   // Walk from the top digit down; a digit is leading-zero only while every
   // digit above it is also zero. Digit 0 always shows.
   always_comb begin
      blank = '0;
      lz    = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz = lz & (cnt[k] == 4'd0);
         if (k != 0) blank[k] = bus.blank_leading & lz;
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_lane
      bcd_counter_7seg_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
         .digit     (cnt[k]),
         .blank     (blank[k]),
         .enable    (bus.enable),
         .lamp_test (bus.lamp_test),
         .seg       (seg_nxt[k])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc  <= '0;
         cnt    <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         sg7_q  <= {DIGITS{SEG_OFF}};
      end else begin
         sg7_q  <= seg_nxt;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         // Load overrides a coincident step: no tick, no wrap, phase restarts.
         if (bus.load) begin
            cnt   <= load_clamped;
            presc <= '0;
         end else if (run) begin
            if (step) begin
               presc  <= '0;
               cnt    <= cnt_nxt;
               tick_q <= 1'b1;
               wrap_q <= roll;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

   assign bus.count = cnt;
   assign bus.sg7   = sg7_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_bcd_counter_7seg_n.sv
module tb_bcd_counter_7seg_n;
   logic clock;
   logic reset;

   bcd_counter_7seg_n_if #(.DIGITS(3)) bus ();

   bcd_counter_7seg_n #(.DIGITS(3), .TICK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        en, ud, ld, lamp, blank;
      logic [11:0] ldv;
      int          ncyc;
      logic [11:0] exp_count;
      logic [20:0] exp_sg7;
      logic        exp_tick, exp_wrap;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic en, ud, ld, lamp, blank, input logic [11:0] ldv, input int ncyc,
                      input logic [11:0] c, input logic [20:0] s, input logic t, w);
      vec_t v;
      v.en = en; v.ud = ud; v.ld = ld; v.lamp = lamp; v.blank = blank; v.ldv = ldv;
      v.ncyc = ncyc; v.exp_count = c; v.exp_sg7 = s; v.exp_tick = t; v.exp_wrap = w;
      vecs.push_back(v);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [11:0] c, input logic [20:0] s,
                            input logic t, input logic w);
      check({tag, " count"}, 32'(bus.count), 32'(c));
      check({tag, " sg7"},   32'(bus.sg7),   32'(s));
      check({tag, " tick"},  32'(bus.tick),  32'(t));
      check({tag, " wrap"},  32'(bus.wrap),  32'(w));
   endtask

   initial begin
      // en ud ld lamp blank ldv    ncyc  count   sg7        tick wrap
      add(1, 1, 0, 0, 0, 12'h000,  3, 12'h000, 21'h102040, 0, 0);
      add(1, 1, 0, 0, 0, 12'h000,  1, 12'h001, 21'h102040, 1, 0);
      add(1, 1, 0, 0, 0, 12'h000,  1, 12'h001, 21'h102079, 0, 0);
      add(1, 1, 0, 0, 0, 12'h000, 31, 12'h009, 21'h102000, 1, 0);
      add(1, 1, 0, 0, 0, 12'h000,  4, 12'h010, 21'h102010, 1, 0);
      add(1, 1, 0, 0, 0, 12'h000,  1, 12'h010, 21'h103CC0, 0, 0);
      add(1, 1, 1, 0, 0, 12'h999,  1, 12'h999, 21'h103CC0, 0, 0);
      add(1, 1, 0, 0, 0, 12'h000,  3, 12'h999, 21'h040810, 0, 0);
      add(1, 1, 0, 0, 0, 12'h000,  1, 12'h000, 21'h040810, 1, 1);
      add(1, 1, 0, 0, 0, 12'h000,  1, 12'h000, 21'h102040, 0, 0);
      add(1, 0, 0, 0, 0, 12'h000,  3, 12'h999, 21'h102040, 1, 1);
      add(1, 0, 0, 0, 0, 12'h000,  4, 12'h998, 21'h040810, 1, 0);
      add(1, 0, 1, 0, 1, 12'h0F5,  1, 12'h095, 21'h040800, 0, 0);
      add(1, 0, 0, 0, 1, 12'h000,  1, 12'h095, 21'h1FC812, 0, 0);
      add(1, 0, 0, 1, 1, 12'h000,  1, 12'h095, 21'h000000, 0, 0);
      add(1, 0, 0, 1, 1, 12'h000, 19, 12'h095, 21'h000000, 0, 0);
      add(1, 0, 0, 0, 1, 12'h000,  2, 12'h095, 21'h1FC812, 0, 0);
      add(1, 0, 0, 0, 1, 12'h000,  1, 12'h094, 21'h1FC812, 1, 0);
      add(1, 0, 1, 0, 1, 12'h000,  1, 12'h000, 21'h1FC819, 0, 0);
      add(1, 0, 0, 0, 1, 12'h000,  1, 12'h000, 21'h1FFFC0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h000,  1, 12'h000, 21'h1FFFFF, 0, 0);
      add(0, 0, 0, 0, 1, 12'h000,  8, 12'h000, 21'h1FFFFF, 0, 0);
      add(0, 0, 1, 0, 1, 12'h321,  1, 12'h321, 21'h1FFFFF, 0, 0);
      add(0, 0, 1, 0, 1, 12'hA7B,  1, 12'h979, 21'h1FFFFF, 0, 0);

      reset = 1'b1;
      bus.enable = 1'b0; bus.up_down = 1'b1; bus.load = 1'b0; bus.load_value = '0;
      bus.lamp_test = 1'b0; bus.blank_leading = 1'b0;
      cyc(2);
      check_all("reset", 12'h000, 21'h1FFFFF, 1'b0, 1'b0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         bus.enable = vecs[i].en; bus.up_down = vecs[i].ud; bus.load = vecs[i].ld;
         bus.lamp_test = vecs[i].lamp; bus.blank_leading = vecs[i].blank;
         bus.load_value = vecs[i].ldv;
         cyc(vecs[i].ncyc);
         check_all($sformatf("row%0d", i), vecs[i].exp_count, vecs[i].exp_sg7,
                   vecs[i].exp_tick, vecs[i].exp_wrap);
      end

      // Reset beats a simultaneous load.
      reset = 1'b1; bus.load = 1'b1; bus.load_value = 12'h555; bus.enable = 1'b1;
      bus.blank_leading = 1'b0; bus.up_down = 1'b1;
      cyc(1);
      check_all("rst_vs_load", 12'h000, 21'h1FFFFF, 1'b0, 1'b0);
      reset = 1'b0; bus.load = 1'b0;

      // Load landing on the step cycle discards the step and restarts the phase.
      cyc(3);
      bus.load = 1'b1; bus.load_value = 12'h999;
      cyc(1);
      check_all("load_on_step", 12'h999, 21'h102040, 1'b0, 1'b0);
      bus.load = 1'b0;
      cyc(3);
      check("phase_restart tick", 32'(bus.tick), 32'd0);
      check("phase_restart count", 32'(bus.count), 32'h999);
      cyc(1);
      check("wrap_after_load count", 32'(bus.count), 32'h000);
      check("wrap_after_load tick", 32'(bus.tick), 32'd1);
      check("wrap_after_load wrap", 32'(bus.wrap), 32'd1);

      // Reset on the would-be step cycle cancels the pending tick.
      bus.load = 1'b1; bus.load_value = 12'h005;
      cyc(1);
      bus.load = 1'b0;
      cyc(3);
      reset = 1'b1;
      cyc(1);
      check("rst_mid count", 32'(bus.count), 32'h000);
      check("rst_mid tick", 32'(bus.tick), 32'd0);
      check("rst_mid wrap", 32'(bus.wrap), 32'd0);
      reset = 1'b0;
      cyc(3);
      check("rst_phase tick", 32'(bus.tick), 32'd0);
      cyc(1);
      check("rst_phase count", 32'(bus.count), 32'h001);
      check("rst_phase tick2", 32'(bus.tick), 32'd1);

      // up_down only matters in the step cycle.
      bus.up_down = 1'b0;
      cyc(2);
      bus.up_down = 1'b1;
      cyc(2);
      check("ud_sample count", 32'(bus.count), 32'h002);
      check("ud_sample tick", 32'(bus.tick), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
